// File: rtl/cc_snoop_responder.sv
// MESI snoop responder for one private L1 cache.
// Takes one bus snoop at a time, drives the tag compare into the cache and
// commits the next MESI state. It returns hit/dirty status (plus write-back
// data for modified lines) to the bus. On local line fills it assigns the
// MESI state that the new line starts in.

// Protocol checker: a local fill may only complete while the unit is idle.
module cc_snoop_responder_chk (
    input  logic CLK,
    input  logic RST,
    input  logic in_idle,
    input  logic fill_valid
);
    // fill_valid outside IDLE would be silently dropped by the FSM
    fill_only_in_idle: assert property (@(posedge CLK) disable iff (RST)
        fill_valid |-> in_idle);
endmodule

module cc_snoop_responder #(
    parameter  int N_SETS   = 16,
    parameter  int WORD_W   = 32,
    localparam int SET_BITS = $clog2(N_SETS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                bus_snoop_valid,
    output logic                bus_snoop_ready,
    input  logic [SET_BITS-1:0] bus_snoop_set,
    input  logic                bus_snoop_inv,
    output logic                bus_resp_valid,
    input  logic                bus_resp_ready,
    output logic                bus_resp_hit,
    output logic                bus_resp_dirty,
    output logic [WORD_W-1:0]   bus_resp_data,
    input  logic                fill_valid,
    input  logic                fill_shared,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic [WORD_W-1:0]   fill_data,
    output logic [SET_BITS-1:0] set_sel,
    output logic [1:0]          state_transfer,
    output logic                state_wen,
    output logic [WORD_W-1:0]   responder_data,
    output logic                snoop_req,
    input  logic                valid,
    input  logic                exclusive,
    input  logic                dirty,
    input  logic                snoop_hit,
    input  logic                write_req,
    input  logic                dWEN,
    input  logic [WORD_W-1:0]   requested_data,
    input  logic [WORD_W-1:0]   frame_tag
);

    localparam logic [1:0] ST_M = 2'd0;
    localparam logic [1:0] ST_E = 2'd1;
    localparam logic [1:0] ST_S = 2'd2;
    localparam logic [1:0] ST_I = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_DECIDE = 3'd2,
        S_WB     = 3'd3,
        S_RESP   = 3'd4,
        S_FILL   = 3'd5
    } fsm_t;

    // Current MESI state from the cache's frame status bits
    function automatic logic [1:0] decode_mesi(input logic v, input logic e, input logic d);
        logic [1:0] st;
        if (!v) begin
            st = ST_I;
        end else if (d) begin
            st = ST_M;
        end else if (e) begin
            st = ST_E;
        end else begin
            st = ST_S;
        end
        return st;
    endfunction

    fsm_t                state_r, state_nxt;
    logic [SET_BITS-1:0] snp_set_r;
    logic                snp_inv_r;
    logic [SET_BITS-1:0] fill_set_r;
    logic [WORD_W-1:0]   fill_data_r;
    logic [1:0]          fill_st_r;
    logic                resp_hit_r, resp_hit_nxt;
    logic                resp_dirty_r, resp_dirty_nxt;
    logic [WORD_W-1:0]   resp_data_r, resp_data_nxt;
    logic                accept_s;
    logic                fill_take_s;
    logic [1:0]          fill_st_s;

    // The tag is carried only for debug visibility
    logic unused_tag_s;
    assign unused_tag_s = ^frame_tag;

    assign bus_resp_hit   = resp_hit_r;
    assign bus_resp_dirty = resp_dirty_r;
    assign bus_resp_data  = resp_data_r;

    // End state of a local fill: a write miss owns the line, otherwise it depends on sharers
    always_comb begin
        if (write_req) begin
            fill_st_s = ST_M;
        end else if (fill_shared) begin
            fill_st_s = ST_S;
        end else begin
            fill_st_s = ST_E;
        end
    end

    // Next-state logic and cache/bus strobes for the snoop/fill FSM
    always_comb begin
        state_nxt       = state_r;
        bus_snoop_ready = 1'b0;
        bus_resp_valid  = 1'b0;
        snoop_req       = 1'b0;
        set_sel         = '0;
        state_transfer  = ST_I;
        state_wen       = 1'b0;
        responder_data  = '0;
        accept_s        = 1'b0;
        fill_take_s     = 1'b0;
        resp_hit_nxt    = resp_hit_r;
        resp_dirty_nxt  = resp_dirty_r;
        resp_data_nxt   = resp_data_r;
        case (state_r)
            S_IDLE: begin
                if (fill_valid) begin
                    // Fill wins over a coincident snoop; the snoop waits
                    fill_take_s = 1'b1;
                    state_nxt   = S_FILL;
                end else begin
                    bus_snoop_ready = !RST;
                    if (bus_snoop_valid) begin
                        accept_s  = 1'b1;
                        state_nxt = S_LOOKUP;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_FILL: begin
                set_sel        = fill_set_r;
                responder_data = fill_data_r;
                state_transfer = fill_st_r;
                state_wen      = 1'b1;
                state_nxt      = S_IDLE;
            end
            S_LOOKUP: begin
                snoop_req = 1'b1;
                set_sel   = snp_set_r;
                state_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                snoop_req = 1'b1;
                set_sel   = snp_set_r;
                if (snoop_hit && valid) begin
                    state_wen      = 1'b1;
                    state_transfer = snp_inv_r ? ST_I : ST_S;
                    if (decode_mesi(valid, exclusive, dirty) == ST_M) begin
                        // Response status is set once the write-back word arrives
                        state_nxt = S_WB;
                    end else begin
                        resp_hit_nxt   = 1'b1;
                        resp_dirty_nxt = 1'b0;
                        resp_data_nxt  = '0;
                        state_nxt      = S_RESP;
                    end
                end else begin
                    resp_hit_nxt   = 1'b0;
                    resp_dirty_nxt = 1'b0;
                    resp_data_nxt  = '0;
                    state_nxt      = S_RESP;
                end
            end
            S_WB: begin
                if (dWEN) begin
                    resp_hit_nxt   = 1'b1;
                    resp_dirty_nxt = 1'b1;
                    resp_data_nxt  = requested_data;
                    state_nxt      = S_RESP;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_RESP: begin
                bus_resp_valid = 1'b1;
                if (bus_resp_ready) begin
                    // Data deliberately keeps its last value after the handshake
                    resp_hit_nxt   = 1'b0;
                    resp_dirty_nxt = 1'b0;
                    state_nxt      = S_IDLE;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and latched snoop/fill/response context
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= S_IDLE;
            snp_set_r    <= '0;
            snp_inv_r    <= 1'b0;
            fill_set_r   <= '0;
            fill_data_r  <= '0;
            fill_st_r    <= ST_I;
            resp_hit_r   <= 1'b0;
            resp_dirty_r <= 1'b0;
            resp_data_r  <= '0;
        end else begin
            state_r      <= state_nxt;
            resp_hit_r   <= resp_hit_nxt;
            resp_dirty_r <= resp_dirty_nxt;
            resp_data_r  <= resp_data_nxt;
            if (accept_s) begin
                snp_set_r <= bus_snoop_set;
                snp_inv_r <= bus_snoop_inv;
            end else begin
                snp_set_r <= snp_set_r;
                snp_inv_r <= snp_inv_r;
            end
            if (fill_take_s) begin
                fill_set_r  <= fill_set;
                fill_data_r <= fill_data;
                fill_st_r   <= fill_st_s;
            end else begin
                fill_set_r  <= fill_set_r;
                fill_data_r <= fill_data_r;
                fill_st_r   <= fill_st_r;
            end
        end
    end

    cc_snoop_responder_chk u_chk (
        .CLK        (CLK),
        .RST        (RST),
        .in_idle    (state_r == S_IDLE),
        .fill_valid (fill_valid)
    );

endmodule

// File: tb/tb_cc_snoop_responder.sv
// Directed bench for cc_snoop_responder: reset, clean/dirty/miss snoops,
// fill priority and end states, and reset in the middle of a write-back.
module tb_cc_snoop_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        bus_snoop_valid, bus_snoop_ready, bus_snoop_inv;
    logic [3:0]  bus_snoop_set;
    logic        bus_resp_valid, bus_resp_ready, bus_resp_hit, bus_resp_dirty;
    logic [31:0] bus_resp_data;
    logic        fill_valid, fill_shared;
    logic [3:0]  fill_set;
    logic [31:0] fill_data;
    logic [3:0]  set_sel;
    logic [1:0]  state_transfer;
    logic        state_wen, snoop_req;
    logic [31:0] responder_data;
    logic        valid, exclusive, dirty, snoop_hit, write_req, dWEN;
    logic [31:0] requested_data, frame_tag;

    int errors = 0;
    int checks = 0;

    cc_snoop_responder #(.N_SETS(16), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .bus_snoop_valid(bus_snoop_valid), .bus_snoop_ready(bus_snoop_ready),
        .bus_snoop_set(bus_snoop_set), .bus_snoop_inv(bus_snoop_inv),
        .bus_resp_valid(bus_resp_valid), .bus_resp_ready(bus_resp_ready),
        .bus_resp_hit(bus_resp_hit), .bus_resp_dirty(bus_resp_dirty),
        .bus_resp_data(bus_resp_data),
        .fill_valid(fill_valid), .fill_shared(fill_shared),
        .fill_set(fill_set), .fill_data(fill_data),
        .set_sel(set_sel), .state_transfer(state_transfer), .state_wen(state_wen),
        .responder_data(responder_data), .snoop_req(snoop_req),
        .valid(valid), .exclusive(exclusive), .dirty(dirty), .snoop_hit(snoop_hit),
        .write_req(write_req), .dWEN(dWEN), .requested_data(requested_data),
        .frame_tag(frame_tag)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cache_in(input logic h, input logic v, input logic e, input logic d);
        snoop_hit = h; valid = v; exclusive = e; dirty = d;
    endtask

    initial begin
        RST = 1'b1;
        bus_snoop_valid = 1'b0; bus_snoop_set = 4'd0; bus_snoop_inv = 1'b0;
        bus_resp_ready = 1'b0;
        fill_valid = 1'b0; fill_shared = 1'b0; fill_set = 4'd0; fill_data = 32'd0;
        cache_in(1'b0, 1'b0, 1'b0, 1'b0);
        write_req = 1'b0; dWEN = 1'b0; requested_data = 32'd0; frame_tag = 32'h0000_1234;
        tick; tick;

        // Reset state
        chk("rst_ready", {31'd0, bus_snoop_ready}, 32'd0);
        chk("rst_xfer", {30'd0, state_transfer}, 32'd3);
        chk("rst_wen", {31'd0, state_wen}, 32'd0);
        chk("rst_sreq", {31'd0, snoop_req}, 32'd0);
        chk("rst_rvalid", {31'd0, bus_resp_valid}, 32'd0);
        chk("rst_data", bus_resp_data, 32'd0);
        RST = 1'b0; #1;
        chk("rel_ready", {31'd0, bus_snoop_ready}, 32'd1);

        // Read snoop, set 5, E line -> SHARED, clean response
        bus_snoop_valid = 1'b1; bus_snoop_set = 4'd5; bus_snoop_inv = 1'b0;
        tick;                                   // LOOKUP
        bus_snoop_valid = 1'b0;
        chk("rd_lk_sreq", {31'd0, snoop_req}, 32'd1);
        chk("rd_lk_set", {28'd0, set_sel}, 32'd5);
        chk("rd_lk_ready", {31'd0, bus_snoop_ready}, 32'd0);
        cache_in(1'b1, 1'b1, 1'b1, 1'b0); #1;
        tick;                                   // DECIDE
        chk("rd_dc_wen", {31'd0, state_wen}, 32'd1);
        chk("rd_dc_xfer", {30'd0, state_transfer}, 32'd2);
        chk("rd_dc_set", {28'd0, set_sel}, 32'd5);
        chk("rd_dc_rvalid", {31'd0, bus_resp_valid}, 32'd0);
        tick;                                   // RESP, 3 cycles after accept
        cache_in(1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("rd_rvalid", {31'd0, bus_resp_valid}, 32'd1);
        chk("rd_hit", {31'd0, bus_resp_hit}, 32'd1);
        chk("rd_dirty", {31'd0, bus_resp_dirty}, 32'd0);
        chk("rd_rs_wen", {31'd0, state_wen}, 32'd0);
        bus_resp_ready = 1'b1;
        tick;                                   // IDLE
        bus_resp_ready = 1'b0; #1;
        chk("rd_done_rvalid", {31'd0, bus_resp_valid}, 32'd0);
        chk("rd_done_hit", {31'd0, bus_resp_hit}, 32'd0);
        chk("rd_done_ready", {31'd0, bus_snoop_ready}, 32'd1);

        // Invalidating snoop, set 2, M line, write-back
        bus_snoop_valid = 1'b1; bus_snoop_set = 4'd2; bus_snoop_inv = 1'b1;
        tick;                                   // LOOKUP
        bus_snoop_valid = 1'b0;
        cache_in(1'b1, 1'b1, 1'b0, 1'b1);
        dWEN = 1'b1; requested_data = 32'h1111_1111;   // early dWEN must be ignored
        #1;
        tick;                                   // DECIDE
        chk("inv_dc_wen", {31'd0, state_wen}, 32'd1);
        chk("inv_dc_xfer", {30'd0, state_transfer}, 32'd3);
        chk("inv_dc_set", {28'd0, set_sel}, 32'd2);
        tick;                                   // WB
        dWEN = 1'b0; cache_in(1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("inv_wb_rvalid", {31'd0, bus_resp_valid}, 32'd0);
        chk("inv_wb_wen", {31'd0, state_wen}, 32'd0);
        tick;                                   // still WB
        chk("inv_wb2_rvalid", {31'd0, bus_resp_valid}, 32'd0);
        dWEN = 1'b1; requested_data = 32'hDEAD_BEEF; #1;
        tick;                                   // RESP
        dWEN = 1'b0; requested_data = 32'h0; #1;
        for (int i = 0; i < 4; i++) begin
            chk("inv_rvalid", {31'd0, bus_resp_valid}, 32'd1);
            chk("inv_hit", {31'd0, bus_resp_hit}, 32'd1);
            chk("inv_dirty", {31'd0, bus_resp_dirty}, 32'd1);
            chk("inv_data", bus_resp_data, 32'hDEAD_BEEF);
            if (i < 3) tick;
        end
        bus_resp_ready = 1'b1;
        tick;                                   // IDLE
        bus_resp_ready = 1'b0; #1;
        chk("inv_done_rvalid", {31'd0, bus_resp_valid}, 32'd0);
        chk("inv_done_dirty", {31'd0, bus_resp_dirty}, 32'd0);
        chk("inv_done_data", bus_resp_data, 32'hDEAD_BEEF);

        // Snoop miss, set 7
        bus_snoop_valid = 1'b1; bus_snoop_set = 4'd7; bus_snoop_inv = 1'b0;
        tick;                                   // LOOKUP
        bus_snoop_valid = 1'b0;
        cache_in(1'b0, 1'b1, 1'b1, 1'b0); #1;
        tick;                                   // DECIDE
        chk("miss_wen", {31'd0, state_wen}, 32'd0);
        chk("miss_set", {28'd0, set_sel}, 32'd7);
        tick;                                   // RESP
        cache_in(1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("miss_rvalid", {31'd0, bus_resp_valid}, 32'd1);
        chk("miss_hit", {31'd0, bus_resp_hit}, 32'd0);
        chk("miss_dirty", {31'd0, bus_resp_dirty}, 32'd0);
        chk("miss_data", bus_resp_data, 32'd0);
        bus_resp_ready = 1'b1;
        tick;
        bus_resp_ready = 1'b0; #1;

        // Fill coincident with a snoop: fill first (EXCLUSIVE), snoop afterwards
        fill_valid = 1'b1; fill_set = 4'd9; fill_data = 32'hCAFE_F00D;
        write_req = 1'b0; fill_shared = 1'b0;
        bus_snoop_valid = 1'b1; bus_snoop_set = 4'd3; bus_snoop_inv = 1'b0; #1;
        chk("fe_ready_blocked", {31'd0, bus_snoop_ready}, 32'd0);
        tick;                                   // FILL
        fill_valid = 1'b0; #1;
        chk("fe_wen", {31'd0, state_wen}, 32'd1);
        chk("fe_xfer", {30'd0, state_transfer}, 32'd1);
        chk("fe_set", {28'd0, set_sel}, 32'd9);
        chk("fe_rdata", responder_data, 32'hCAFE_F00D);
        chk("fe_sreq", {31'd0, snoop_req}, 32'd0);
        tick;                                   // IDLE, snoop accepted
        chk("fe_idle_ready", {31'd0, bus_snoop_ready}, 32'd1);
        chk("fe_idle_wen", {31'd0, state_wen}, 32'd0);
        tick;                                   // LOOKUP
        bus_snoop_valid = 1'b0; #1;
        chk("fe_lk_sreq", {31'd0, snoop_req}, 32'd1);
        chk("fe_lk_set", {28'd0, set_sel}, 32'd3);
        tick; tick;                             // DECIDE (miss), RESP
        chk("fe_rvalid", {31'd0, bus_resp_valid}, 32'd1);
        bus_resp_ready = 1'b1;
        tick;
        bus_resp_ready = 1'b0;

        // Write-miss fill -> MODIFIED, shared read fill -> SHARED
        fill_valid = 1'b1; fill_set = 4'd4; fill_data = 32'h0BAD_CAFE; write_req = 1'b1; #1;
        tick;
        fill_valid = 1'b0; write_req = 1'b0; #1;
        chk("fm_xfer", {30'd0, state_transfer}, 32'd0);
        chk("fm_set", {28'd0, set_sel}, 32'd4);
        tick;
        fill_valid = 1'b1; fill_set = 4'd15; fill_shared = 1'b1; #1;
        tick;
        fill_valid = 1'b0; fill_shared = 1'b0; #1;
        chk("fs_xfer", {30'd0, state_transfer}, 32'd2);
        chk("fs_set", {28'd0, set_sel}, 32'd15);
        tick;

        // Reset while waiting in WB
        bus_snoop_valid = 1'b1; bus_snoop_set = 4'd1; bus_snoop_inv = 1'b0;
        tick;                                   // LOOKUP
        bus_snoop_valid = 1'b0;
        cache_in(1'b1, 1'b1, 1'b0, 1'b1); #1;
        tick;                                   // DECIDE
        tick;                                   // WB
        cache_in(1'b0, 1'b0, 1'b0, 1'b0); #1;
        chk("rwb_rvalid", {31'd0, bus_resp_valid}, 32'd0);
        RST = 1'b1; #1;
        chk("rwb_ready_rst", {31'd0, bus_snoop_ready}, 32'd0);
        tick;                                   // IDLE via reset
        chk("rwb_rvalid_rst", {31'd0, bus_resp_valid}, 32'd0);
        chk("rwb_xfer", {30'd0, state_transfer}, 32'd3);
        chk("rwb_wen", {31'd0, state_wen}, 32'd0);
        chk("rwb_hit", {31'd0, bus_resp_hit}, 32'd0);
        chk("rwb_dirty", {31'd0, bus_resp_dirty}, 32'd0);
        chk("rwb_data", bus_resp_data, 32'd0);
        RST = 1'b0; dWEN = 1'b1; requested_data = 32'h5555_AAAA; #1;
        chk("rwb_ready_rel", {31'd0, bus_snoop_ready}, 32'd1);
        tick; tick;
        dWEN = 1'b0; #1;
        chk("rwb_no_resp", {31'd0, bus_resp_valid}, 32'd0);
        chk("rwb_no_data", bus_resp_data, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cc_snoop_responder.md
Name: cc_snoop_responder

Overview:
- Coherency-unit end of the cache coherence interface for one private L1 under MESI.
- Accepts snoops from the shared bus and drives snoop_req/set_sel into the cache.
- Samples the cache's tag-match and state bits, computes and commits the next MESI state through state_transfer, returns hit/dirty data to the bus, and assigns the end state on local line fills.

Parameters:
N_SETS, 16, number of cache sets; SET_BITS = $clog2(N_SETS)
WORD_W, 32, data/tag width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
bus_snoop_valid  in  1  bus snoop request valid
bus_snoop_ready  out  1  unit can accept a snoop
bus_snoop_set  in  SET_BITS  snooped set index
bus_snoop_inv  in  1  1 = invalidating (write/RFO) snoop, 0 = read snoop
bus_resp_valid  out  1  snoop response valid
bus_resp_ready  in  1  bus accepts response
bus_resp_hit  out  1  line present in this cache
bus_resp_dirty  out  1  bus_resp_data carries modified data
bus_resp_data  out  WORD_W  write-back word
fill_valid  in  1  local line fill completing this cycle
fill_shared  in  1  another cache holds the line
fill_set  in  SET_BITS  set being filled
fill_data  in  WORD_W  fill word from bus
set_sel  out  SET_BITS  set index to cache
state_transfer  out  2  cc_end_state to commit (MODIFIED=0, EXCLUSIVE=1, SHARED=2, INVALID=3)
state_wen  out  1  one-cycle strobe: cache writes state_transfer into set_sel
responder_data  out  WORD_W  fill data to cache
snoop_req  out  1  cache performs tag compare on set_sel
valid, exclusive, dirty  in  1 each  cache state bits of the selected frame
snoop_hit  in  1  snoop tag matched
write_req  in  1  outstanding local miss is a write
dWEN  in  1  cache presents write-back word on requested_data
requested_data  in  WORD_W  cache data out
frame_tag  in  WORD_W  frame tag (unused internally; passed for debug)

Behaviour:
- Reset (RST high at a CLK edge): FSM=IDLE; all outputs 0 except state_transfer=INVALID. RST mid-operation abandons any snoop; no response is issued; bus_snoop_ready=0 while RST is high.
- Current-state decode: !valid->I; dirty->M; exclusive->E; else S.
- FSM states: IDLE, LOOKUP, DECIDE, WB, RESP, FILL.
- IDLE:
  - bus_snoop_ready=1 unless fill_valid.
  - fill_valid -> FILL; fill has priority when it coincides with a snoop (snoop not accepted that cycle).
  - bus_snoop_valid&ready -> latch set and inv -> LOOKUP.
- FILL (1 cycle):
  - set_sel=fill_set, responder_data=fill_data, state_wen=1.
  - state_transfer = M if write_req, else S if fill_shared, else E.
  - -> IDLE.
- LOOKUP (1 cycle): snoop_req=1, set_sel=latched set -> DECIDE.
- DECIDE (1 cycle): snoop_req=1; sample snoop_hit&valid as hit.
  - Miss: no state_wen -> RESP with hit=0, dirty=0, data=0.
  - Hit: state_wen=1.
    - state_transfer = INVALID if inv; else SHARED (M->S, E->S, S->S).
    - Current state M -> WB; else -> RESP with hit=1, dirty=0.
- WB: wait for dWEN (no timeout); on dWEN capture requested_data into bus_resp_data, dirty=1 -> RESP. A dWEN asserted in DECIDE is ignored.
- RESP: bus_resp_valid=1; hit/dirty/data held stable until bus_resp_ready; then -> IDLE, clearing valid/hit/dirty. Data retains its last value.
- Latency:
  - Clean snoop: response valid 3 cycles after acceptance.
  - Dirty snoop: response valid 1 cycle after dWEN.
  - Back-to-back snoops: at least 4 cycles apart.
- Only one snoop is in flight. fill_valid outside IDLE is a protocol violation; the unit asserts against it in simulation.

Test Plan:
- Reset -> bus_snoop_ready=0, state_transfer=3, all strobes 0; release -> bus_snoop_ready=1.
- Read snoop set 5, cache returns hit, valid=1, exclusive=1, dirty=0 -> state_wen in DECIDE with state_transfer=SHARED, set_sel=5; resp hit=1, dirty=0, 3 cycles after acceptance.
- Invalidating snoop set 2, M line, dWEN 2 cycles after DECIDE with requested_data=0xDEADBEEF -> state_transfer=INVALID; resp dirty=1, data=0xDEADBEEF; resp held through 3 cycles of bus_resp_ready=0.
- Snoop miss (snoop_hit=0) -> no state_wen; resp hit=0, dirty=0.
- fill_valid and bus_snoop_valid in the same IDLE cycle, write_req=0, fill_shared=0 -> FILL first with state_transfer=EXCLUSIVE, snoop accepted next cycle; repeat with write_req=1 -> MODIFIED.
- RST asserted in WB -> IDLE next cycle, no bus_resp_valid, outputs at reset values.
